io_bus_arbiter: RTL

Two-requester arbiter and sequencer for the memory-mapped I/O port block (LED/button/switch registers).
- Requester 0 is the CPU load/store unit; requester 1 is the debug/monitor port.
- Grants the single I/O bus to one requester at a time, round-robin, and drives the I/O block's addr/data/write.
- Waits out the I/O block's one-cycle registered read latency, then returns read data to the winning requester.

---
 rtl/io_bus_arbiter_if.sv | 73 +++++++
 rtl/io_bus_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/io_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : io_bus_arbiter_if
// Description : Bundle of request/response handshakes for the two requesters
//               and the bus to the memory-mapped I/O port block.
//               slave  modport - seen by the arbiter
//               master modport - seen by the requesters / I/O block side
//               Signals:
//                 req_valid/req_write/req_addr/req_wdata  requester -> arbiter
//                 req_ready/resp_valid/resp_data          arbiter -> requester
//                 io_addr/io_data/io_write                arbiter -> I/O block
//                 io_rdata                                I/O block -> arbiter
//                 busy                                    arbiter status
//               Optional: IO_BUS_ARBITER_LOCK_EN adds req_lock[1:0].
// Revision    : 1.0 - initial release
// ============================================================================
interface io_bus_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [1:0]          req_valid;
    logic [1:0]          req_write;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          req_ready;
    logic [1:0]          resp_valid;
    logic [DATA_W-1:0]   resp_data;
    logic [ADDR_W-1:0]   io_addr;
    logic [DATA_W-1:0]   io_data;
    logic                io_write;
    logic [DATA_W-1:0]   io_rdata;
    logic                busy;
`ifdef IO_BUS_ARBITER_LOCK_EN
    logic [1:0]          req_lock;
`endif

    modport slave (
`ifdef IO_BUS_ARBITER_LOCK_EN
        input  req_lock,
`endif
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output resp_valid,
        output resp_data,
        output io_addr,
        output io_data,
        output io_write,
        input  io_rdata,
        output busy
    );

    modport master (
`ifdef IO_BUS_ARBITER_LOCK_EN
        output req_lock,
`endif
        output req_valid,
        output req_write,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  resp_valid,
        input  resp_data,
        input  io_addr,
        input  io_data,
        input  io_write,
        output io_rdata,
        input  busy
    );
endinterface : io_bus_arbiter_if
`default_nettype wire

// File: rtl/io_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : io_bus_arbiter
// Description : Two-requester round-robin arbiter and sequencer for the
//               memory-mapped I/O port block. Requester 0 is the CPU
//               load/store unit, requester 1 the debug/monitor port.
//               One transaction is in flight at a time:
//                 IDLE -> ISSUE -> RESP          (write)
//                 IDLE -> ISSUE -> WAIT -> RESP  (read, covers the I/O
//                                                 block's registered read)
//               Ports:
//                 clk       system clock, rising edge
//                 sync_rst  synchronous reset, active low
//                 bus       io_bus_arbiter_if.slave (requests, responses,
//                           I/O block bus, busy)
//               Optional: define IO_BUS_ARBITER_LOCK_EN to enable req_lock,
//               which lets a granted requester keep exclusive ownership of
//               arbitration until it is granted with its lock low.
// Revision    : 1.0 - initial release
// ============================================================================
module io_bus_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic            clk,
    input  logic            sync_rst,
    io_bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    // Round-robin pointer: the requester that wins when both are valid.
    logic                r_rr_ptr;
    // Requester that owns the in-flight transaction.
    logic                r_owner;
    logic                r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_resp_data;

    logic [1:0]          w_eligible;
    logic                w_winner;
    logic                w_grant;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_sel_write;
    logic [1:0]          w_req_ready;
    logic [1:0]          w_resp_valid;
    logic                w_io_write;

    // ------------------------------------------------------------------
    // Eligibility: with locking, a lock holder masks the other requester
    // out of arbitration entirely (even if the holder is not requesting).
    // ------------------------------------------------------------------
`ifdef IO_BUS_ARBITER_LOCK_EN
    logic r_lock_active;
    logic r_lock_owner;

    always_comb begin
        w_eligible = bus.req_valid;
        if (r_lock_active) begin
            w_eligible = bus.req_valid & (r_lock_owner ? 2'b10 : 2'b01);
        end
    end
`else
    assign w_eligible = bus.req_valid;
`endif

    // Winner select: a lone requester wins outright, a tie goes to r_rr_ptr.
    always_comb begin
        w_winner = 1'b0;
        case (w_eligible)
            2'b01:   w_winner = 1'b0;
            2'b10:   w_winner = 1'b1;
            2'b11:   w_winner = r_rr_ptr;
            default: w_winner = 1'b0;
        endcase
    end

    assign w_grant     = (r_state == ST_IDLE) && (|w_eligible);
    assign w_sel_addr  = w_winner ? bus.req_addr[2*ADDR_W-1:ADDR_W]
                                  : bus.req_addr[ADDR_W-1:0];
    assign w_sel_wdata = w_winner ? bus.req_wdata[2*DATA_W-1:DATA_W]
                                  : bus.req_wdata[DATA_W-1:0];
    assign w_sel_write = bus.req_write[w_winner];

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_req_ready  = 2'b00;
        w_resp_valid = 2'b00;
        w_io_write   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_req_ready  = w_winner ? 2'b10 : 2'b01;
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_io_write   = r_write;
                // Writes need no read-latency slot.
                w_next_state = r_write ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                w_resp_valid = r_owner ? 2'b10 : 2'b01;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!sync_rst) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= 1'b0;
            r_owner     <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_resp_data <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_grant) begin
                r_owner     <= w_winner;
                r_rr_ptr    <= ~w_winner;
                r_write     <= w_sel_write;
                r_addr      <= w_sel_addr;
                r_wdata     <= w_sel_wdata;
                // Cleared here so that write responses carry zero data.
                r_resp_data <= '0;
            end
            if (r_state == ST_WAIT) begin
                r_resp_data <= bus.io_rdata;
            end
        end
    end

`ifdef IO_BUS_ARBITER_LOCK_EN
    // Lock state follows the lock bit of each grant: set when the winner
    // is granted with req_lock high, released by a grant with it low.
    always_ff @(posedge clk) begin
        if (!sync_rst) begin
            r_lock_active <= 1'b0;
            r_lock_owner  <= 1'b0;
        end else if (w_grant) begin
            r_lock_active <= bus.req_lock[w_winner];
            r_lock_owner  <= w_winner;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs. io_addr/io_data are driven from the latch at all times;
    // only io_write qualifies the cycle, and I/O reads have no side effects.
    // ------------------------------------------------------------------
    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = w_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.io_addr    = r_addr;
    assign bus.io_data    = r_wdata;
    assign bus.io_write   = w_io_write;
    assign bus.busy       = (r_state != ST_IDLE);

endmodule : io_bus_arbiter
`default_nettype wire
